soc_addr_decoder: RTL and testbench

//  Runtime-programmable SoC address decoder that maps a request address to a slave

---
 rtl/soc_addr_decoder.sv | 149 ++++++++++++++
 tb/tb_soc_addr_decoder.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_addr_decoder.sv
// soc_addr_decoder: runtime-programmable address decoder.
// Holds NrRules base/length/enable entries written through a small config port.
// The table can be locked until the next reset. Lookups pass through one
// registered valid/ready stage: latency 1, one result per cycle.
// Optional feature macro: SOC_ADDR_DECODER_MISS_LOG_EN adds a saturating miss
// counter and a register holding the last missed address.
module soc_addr_decoder #(
  parameter int AddrWidth  = 64,
  parameter int NrRules    = 10,
  parameter int IdxWidth   = (NrRules > 1) ? $clog2(NrRules) : 1,
  parameter int DefaultIdx = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_we_i,
  input  logic [IdxWidth-1:0]  cfg_rule_i,
  input  logic [1:0]           cfg_field_i,
  input  logic [AddrWidth-1:0] cfg_wdata_i,
  output logic                 cfg_err_o,
  output logic                 locked_o,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IdxWidth-1:0]  resp_idx_o,
  output logic                 resp_hit_o
`ifdef SOC_ADDR_DECODER_MISS_LOG_EN
  ,
  output logic [31:0]          miss_cnt_o,
  output logic [AddrWidth-1:0] miss_addr_o
`endif
);

  // The output stage is the only state machine: EMPTY or FULL.
  localparam logic StateEmpty = 1'b0;
  localparam logic StateFull  = 1'b1;

  localparam logic [IdxWidth-1:0] DefIdx = IdxWidth'(DefaultIdx);

  localparam logic [1:0] FieldBase = 2'd0;
  localparam logic [1:0] FieldLen  = 2'd1;
  localparam logic [1:0] FieldEn   = 2'd2;
  localparam logic [1:0] FieldLock = 2'd3;

  logic [AddrWidth-1:0] base_q [NrRules];
  logic [AddrWidth-1:0] len_q  [NrRules];
  logic [NrRules-1:0]   en_q;
  logic                 lock_q;
  logic                 cfg_err_q;
  logic                 state_q;
  logic [IdxWidth-1:0]  idx_q;
  logic                 hit_q;

  logic                 rule_oor;
  logic                 cfg_reject;
  logic                 accept;
  logic [IdxWidth-1:0]  match_idx;
  logic                 match_hit;

  assign rule_oor     = (32'(cfg_rule_i) >= 32'(NrRules));
  assign cfg_reject   = cfg_we_i && (lock_q || rule_oor);
  assign resp_valid_o = (state_q == StateFull);
  assign req_ready_o  = !resp_valid_o || resp_ready_i;
  assign accept       = req_valid_i && req_ready_o;

  assign cfg_err_o    = cfg_err_q;
  assign locked_o     = lock_q;
  assign resp_idx_o   = idx_q;
  assign resp_hit_o   = hit_q;

  // Priority match over the current table; scanning downwards lets the lowest
  // matching index overwrite any higher one. Subtracting instead of adding
  // base+length keeps rules that run past the top of the space correct.
  always_comb begin
    match_idx = DefIdx;
    match_hit = 1'b0;
    for (int i = NrRules - 1; i >= 0; i--) begin
      if (en_q[i] && (req_addr_i >= base_q[i]) &&
          ((req_addr_i - base_q[i]) < len_q[i])) begin
        match_idx = IdxWidth'(i);
        match_hit = 1'b1;
      end
    end
  end

  // Config table and lock; rejected writes only raise the one-cycle error pulse.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < NrRules; i++) begin
        base_q[i] <= '0;
        len_q[i]  <= '0;
      end
      en_q      <= '0;
      lock_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_reject;
      if (cfg_we_i && !cfg_reject) begin
        case (cfg_field_i)
          FieldBase: base_q[cfg_rule_i] <= cfg_wdata_i;
          FieldLen:  len_q[cfg_rule_i]  <= cfg_wdata_i;
          FieldEn:   en_q[cfg_rule_i]   <= cfg_wdata_i[0];
          FieldLock: if (cfg_wdata_i[0]) lock_q <= 1'b1;
          default:   ;
        endcase
      end
    end
  end

  // Response stage: capture the match on accept, hold it while stalled, and
  // empty once the consumer takes it with nothing new behind it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StateEmpty;
      idx_q   <= '0;
      hit_q   <= 1'b0;
    end else if (accept) begin
      state_q <= StateFull;
      idx_q   <= match_idx;
      hit_q   <= match_hit;
    end else if (resp_ready_i) begin
      state_q <= StateEmpty;
    end
  end

`ifdef SOC_ADDR_DECODER_MISS_LOG_EN
  logic [31:0]          miss_cnt_q;
  logic [AddrWidth-1:0] miss_addr_q;

  assign miss_cnt_o  = miss_cnt_q;
  assign miss_addr_o = miss_addr_q;

  // Miss log: count accepted lookups that matched nothing, saturating at all-ones,
  // and remember the most recent missed address.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      miss_cnt_q  <= '0;
      miss_addr_q <= '0;
    end else if (accept && !match_hit) begin
      if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      miss_addr_q <= req_addr_i;
    end
  end
`else
  // Without the miss log the decoder keeps no statistics state.
`endif

endmodule

// File: tb/tb_soc_addr_decoder.sv
// Testbench for soc_addr_decoder: table-driven lookups checked through a
// scoreboard queue, plus hand-written stall, config-ordering, lock and reset cases.
module tb_soc_addr_decoder;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        cfg_we_i;
  logic [3:0]  cfg_rule_i;
  logic [1:0]  cfg_field_i;
  logic [63:0] cfg_wdata_i;
  logic        cfg_err_o;
  logic        locked_o;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [63:0] req_addr_i;
  logic        resp_valid_o;
  logic        resp_ready_i;
  logic [3:0]  resp_idx_o;
  logic        resp_hit_o;
`ifdef SOC_ADDR_DECODER_MISS_LOG_EN
  logic [31:0] miss_cnt_o;
  logic [63:0] miss_addr_o;
`endif

  soc_addr_decoder dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .cfg_we_i     (cfg_we_i),
    .cfg_rule_i   (cfg_rule_i),
    .cfg_field_i  (cfg_field_i),
    .cfg_wdata_i  (cfg_wdata_i),
    .cfg_err_o    (cfg_err_o),
    .locked_o     (locked_o),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_idx_o   (resp_idx_o),
    .resp_hit_o   (resp_hit_o)
`ifdef SOC_ADDR_DECODER_MISS_LOG_EN
    ,
    .miss_cnt_o   (miss_cnt_o),
    .miss_addr_o  (miss_addr_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] addr;
    logic [3:0]  idx;
    logic        hit;
  } vec_t;

  typedef struct {
    logic [3:0] idx;
    logic       hit;
  } resp_t;

  vec_t  vecs [15];
  resp_t sb_q [$];
  logic  exp_valid;
  logic  exp_err;
  int    checks;
  int    failures;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sets up a config write for the next applyStimulus cycle.
  task automatic cfgWrite(input logic [3:0] rule, input logic [1:0] field,
                          input logic [63:0] data, input logic err);
    cfg_we_i    = 1'b1;
    cfg_rule_i  = rule;
    cfg_field_i = field;
    cfg_wdata_i = data;
    exp_err     = err;
  endtask

  // One clock cycle: check ready and the pending result, push the expected
  // result on accept, then check valid and the config error after the edge.
  task automatic applyStimulus(input logic rv, input logic [63:0] addr, input logic rr,
                               input logic [3:0] eidx, input logic ehit);
    logic  model_ready;
    logic  acc;
    resp_t r;
    req_valid_i  = rv;
    req_addr_i   = addr;
    resp_ready_i = rr;
    #1;
    model_ready = !exp_valid || rr;
    checkOutput("req_ready", {63'd0, req_ready_o}, {63'd0, model_ready});
    if (exp_valid) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty: got result with no expected entry");
      end else begin
        r = sb_q[0];
        checkOutput("resp_idx", {60'd0, resp_idx_o}, {60'd0, r.idx});
        checkOutput("resp_hit", {63'd0, resp_hit_o}, {63'd0, r.hit});
        if (rr) void'(sb_q.pop_front());
      end
    end
    acc = rv && model_ready;
    if (acc) begin
      r.idx = eidx;
      r.hit = ehit;
      sb_q.push_back(r);
    end
    @(posedge clk_i);
    #1;
    if (acc) exp_valid = 1'b1;
    else if (rr) exp_valid = 1'b0;
    checkOutput("resp_valid", {63'd0, resp_valid_o}, {63'd0, exp_valid});
    checkOutput("cfg_err", {63'd0, cfg_err_o}, {63'd0, exp_err});
    cfg_we_i = 1'b0;
    exp_err  = 1'b0;
    req_valid_i = 1'b0;
  endtask

  task automatic cfgOnly(input logic [3:0] rule, input logic [1:0] field,
                         input logic [63:0] data, input logic err);
    cfgWrite(rule, field, data, err);
    applyStimulus(1'b0, 64'd0, 1'b1, 4'd0, 1'b0);
  endtask

  task automatic drain();
    applyStimulus(1'b0, 64'd0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b1, 4'd0, 1'b0);
    checkOutput("sb_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic doReset();
    rst_ni = 1'b0;
    req_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    cfg_we_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_resp_valid", {63'd0, resp_valid_o}, 64'd0);
    checkOutput("rst_resp_idx", {60'd0, resp_idx_o}, 64'd0);
    checkOutput("rst_resp_hit", {63'd0, resp_hit_o}, 64'd0);
    checkOutput("rst_cfg_err", {63'd0, cfg_err_o}, 64'd0);
    checkOutput("rst_locked", {63'd0, locked_o}, 64'd0);
    checkOutput("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
    sb_q.delete();
    exp_valid = 1'b0;
    exp_err = 1'b0;
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    cfg_rule_i = '0;
    cfg_field_i = '0;
    cfg_wdata_i = '0;
    req_addr_i = '0;

    vecs[0]  = '{64'h0000_0000_BFFF_FFFF, 4'd0, 1'b1};
    vecs[1]  = '{64'h0000_0000_C000_0000, 4'd0, 1'b0};
    vecs[2]  = '{64'h0000_0000_8000_0000, 4'd0, 1'b1};
    vecs[3]  = '{64'h0000_0000_7FFF_FFFF, 4'd0, 1'b0};
    vecs[4]  = '{64'h0000_0000_1000_0800, 4'd2, 1'b1};
    vecs[5]  = '{64'h0000_0000_1000_1800, 4'd5, 1'b1};
    vecs[6]  = '{64'h0000_0000_1000_0FFF, 4'd2, 1'b1};
    vecs[7]  = '{64'h0000_0000_1000_1000, 4'd5, 1'b1};
    vecs[8]  = '{64'h0000_0000_1001_0000, 4'd0, 1'b0};
    vecs[9]  = '{64'h0000_0000_0FFF_FFFF, 4'd0, 1'b0};
    vecs[10] = '{64'h0000_0000_2000_0000, 4'd0, 1'b0};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFF, 4'd7, 1'b1};
    vecs[12] = '{64'hFFFF_FFFF_FFFF_F000, 4'd7, 1'b1};
    vecs[13] = '{64'hFFFF_FFFF_FFFF_EFFF, 4'd0, 1'b0};
    vecs[14] = '{64'h0000_0000_3000_0010, 4'd0, 1'b0};

    doReset();

    // Empty table: everything misses with the default index.
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 4'd0, 1'b0);

    cfgOnly(4'd0, 2'd0, 64'h8000_0000, 1'b0);
    cfgOnly(4'd0, 2'd1, 64'h4000_0000, 1'b0);
    cfgOnly(4'd0, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd2, 2'd0, 64'h1000_0000, 1'b0);
    cfgOnly(4'd2, 2'd1, 64'h1000, 1'b0);
    cfgOnly(4'd2, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd5, 2'd0, 64'h1000_0000, 1'b0);
    cfgOnly(4'd5, 2'd1, 64'h1_0000, 1'b0);
    cfgOnly(4'd5, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd3, 2'd0, 64'h2000_0000, 1'b0);
    cfgOnly(4'd3, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd7, 2'd0, 64'hFFFF_FFFF_FFFF_F000, 1'b0);
    cfgOnly(4'd7, 2'd1, 64'h2000, 1'b0);
    cfgOnly(4'd7, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd8, 2'd0, 64'h3000_0000, 1'b0);
    cfgOnly(4'd8, 2'd1, 64'h100, 1'b0);

    // Back-to-back table lookups.
    for (int i = 0; i < 15; i++)
      applyStimulus(1'b1, vecs[i].addr, 1'b1, vecs[i].idx, vecs[i].hit);
    drain();

    // Stall three cycles with a pending request, then stream three results.
    applyStimulus(1'b1, 64'h1000_0800, 1'b1, 4'd2, 1'b1);
    repeat (3) applyStimulus(1'b1, 64'h1000_1800, 1'b0, 4'd5, 1'b1);
    applyStimulus(1'b1, 64'h1000_1800, 1'b1, 4'd5, 1'b1);
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 4'd0, 1'b1);
    applyStimulus(1'b1, 64'hC000_0000, 1'b1, 4'd0, 1'b0);
    drain();

    // Same-cycle write and lookup: the lookup sees the old rule0 base.
    cfgWrite(4'd0, 2'd0, 64'h9000_0000, 1'b0);
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 4'd0, 1'b1);
    applyStimulus(1'b1, 64'h8000_0000, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 64'h9000_0000, 1'b1, 4'd0, 1'b1);
    drain();

    // A held result is not recomputed by a later write.
    applyStimulus(1'b1, 64'h9000_0010, 1'b1, 4'd0, 1'b1);
    cfgWrite(4'd0, 2'd2, 64'd0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b0, 64'd0, 1'b0, 4'd0, 1'b0);
    applyStimulus(1'b1, 64'h9000_0010, 1'b1, 4'd0, 1'b0);
    drain();

    // Rule1 programmed, bad rule index rejected, lock-clear write is a no-op.
    cfgOnly(4'd1, 2'd0, 64'h5000_0000, 1'b0);
    cfgOnly(4'd1, 2'd1, 64'h100, 1'b0);
    cfgOnly(4'd1, 2'd2, 64'd1, 1'b0);
    cfgOnly(4'd12, 2'd2, 64'd1, 1'b1);
    cfgOnly(4'd3, 2'd3, 64'd0, 1'b0);
    checkOutput("locked_after_clear_write", {63'd0, locked_o}, 64'd0);

    // Lock, then every write is rejected and rule1 keeps its old range.
    cfgOnly(4'd9, 2'd3, 64'd1, 1'b0);
    checkOutput("locked_set", {63'd0, locked_o}, 64'd1);
    cfgWrite(4'd1, 2'd0, 64'h6000_0000, 1'b1);
    applyStimulus(1'b0, 64'd0, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 64'h5000_0010, 1'b1, 4'd1, 1'b1);
    applyStimulus(1'b1, 64'h6000_0010, 1'b1, 4'd0, 1'b0);
    cfgWrite(4'd1, 2'd2, 64'd0, 1'b1);
    applyStimulus(1'b1, 64'h5000_0010, 1'b1, 4'd1, 1'b1);
    applyStimulus(1'b1, 64'h5000_0010, 1'b1, 4'd1, 1'b1);
    cfgOnly(4'd1, 2'd3, 64'd0, 1'b1);
    checkOutput("locked_sticky", {63'd0, locked_o}, 64'd1);
    drain();

    // Reset with a result in flight clears it along with the table and lock.
    applyStimulus(1'b1, 64'h5000_0010, 1'b0, 4'd1, 1'b1);
    doReset();
    applyStimulus(1'b1, 64'h5000_0010, 1'b1, 4'd0, 1'b0);
    drain();

`ifdef SOC_ADDR_DECODER_MISS_LOG_EN
    doReset();
    checkOutput("miss_cnt_reset", {32'd0, miss_cnt_o}, 64'd0);
    applyStimulus(1'b1, 64'h7000_0000, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 64'h7100_0000, 1'b1, 4'd0, 1'b0);
    applyStimulus(1'b1, 64'h7200_0000, 1'b1, 4'd0, 1'b0);
    drain();
    checkOutput("miss_cnt_3", {32'd0, miss_cnt_o}, 64'd3);
    checkOutput("miss_addr_last", miss_addr_o, 64'h7200_0000);
    force dut.miss_cnt_q = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.miss_cnt_q;
    applyStimulus(1'b1, 64'h7300_0000, 1'b1, 4'd0, 1'b0);
    drain();
    checkOutput("miss_cnt_sat", {32'd0, miss_cnt_o}, 64'hFFFF_FFFF);
    checkOutput("miss_addr_sat", miss_addr_o, 64'h7300_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
